// File: rtl/fpmul_rr_sched.sv
// fpmul_rr_sched: round-robin scheduler sharing one fixed-latency FP16 multiplier
// between NREQ requesters. Grants at most one request per cycle, issues it to
// the multiplier one cycle later, tracks the owner ID through a LAT-deep tag
// pipeline and routes the returning product back to that requester.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   req_valid_i          per-requester operand-pair valid
//   req_opA_i/req_opB_i  packed FP16 operands, requester k at [16k+15:16k]
//   req_ready_o          one-hot grant (combinational)
//   mul_valid_o          issue strobe to the shared multiplier
//   mul_opA_o/mul_opB_o  operands to the multiplier (hold last issued value)
//   mul_valid_i          product valid from the multiplier
//   mul_res_i            FP16 product from the multiplier
//   resp_valid_o         response strobe, no backpressure
//   resp_id_o            requester owning the response
//   resp_data_o          FP16 product
//   op_count_o           multiplies issued since reset, wraps
//   err_o                sticky protocol error
module fpmul_rr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [16*NREQ-1:0]   req_opA_i,
  input  logic [16*NREQ-1:0]   req_opB_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 mul_valid_o,
  output logic [15:0]          mul_opA_o,
  output logic [15:0]          mul_opB_o,
  input  logic                 mul_valid_i,
  input  logic [15:0]          mul_res_i,
  output logic                 resp_valid_o,
  output logic [IDW-1:0]       resp_id_o,
  output logic [15:0]          resp_data_o,
  output logic [15:0]          op_count_o,
  output logic                 err_o
);

  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(LAT + 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           mul_valid_q, mul_valid_d;
  logic [15:0]    mul_opA_q, mul_opA_d;
  logic [15:0]    mul_opB_q, mul_opB_d;
  logic [IDW-1:0] iss_id_q, iss_id_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [15:0]    resp_data_q, resp_data_d;
  logic [15:0]    op_count_q, op_count_d;
  logic           err_q, err_d;
  logic           tag_v_q  [LAT];
  logic [IDW-1:0] tag_id_q [LAT];

  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic           arb_en;
  logic           accept;
  logic           chk_en;

  // Grants are blocked in reset and while stale pre-reset products drain.
  assign arb_en = !rst_i && (drain_q == '0);
  assign accept = arb_en && gnt_vld;
  assign chk_en = (drain_q == '0);

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!gnt_vld && req_valid_i[IDW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  assign req_ready_o = accept ? (NREQ'(1) << gnt_id) : '0;

  // Next-state for pointer, issue, return and status registers.
  always_comb begin
    ptr_d        = ptr_q;
    drain_d      = drain_q;
    mul_valid_d  = 1'b0;
    mul_opA_d    = mul_opA_q;
    mul_opB_d    = mul_opB_q;
    iss_id_d     = iss_id_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    op_count_d   = op_count_q;
    err_d        = err_q;

    if (drain_q != '0) begin
      drain_d = drain_q - DW'(1);
    end

    if (accept) begin
      ptr_d       = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      mul_valid_d = 1'b1;
      mul_opA_d   = req_opA_i[16*gnt_id +: 16];
      mul_opB_d   = req_opB_i[16*gnt_id +: 16];
      iss_id_d    = gnt_id;
      op_count_d  = op_count_q + 16'd1;
    end

    // Products are only honoured when a tag is expecting them.
    if (chk_en) begin
      if (mul_valid_i && tag_v_q[LAT-1]) begin
        resp_valid_d = 1'b1;
        resp_id_d    = tag_id_q[LAT-1];
        resp_data_d  = mul_res_i;
      end
      if (mul_valid_i != tag_v_q[LAT-1]) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers and tag pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      drain_q      <= DRAIN_INIT;
      mul_valid_q  <= 1'b0;
      mul_opA_q    <= '0;
      mul_opB_q    <= '0;
      iss_id_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      op_count_q   <= '0;
      err_q        <= 1'b0;
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_v_q[i]  <= 1'b0;
        tag_id_q[i] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      drain_q      <= drain_d;
      mul_valid_q  <= mul_valid_d;
      mul_opA_q    <= mul_opA_d;
      mul_opB_q    <= mul_opB_d;
      iss_id_q     <= iss_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      op_count_q   <= op_count_d;
      err_q        <= err_d;
      tag_v_q[0]   <= mul_valid_q;
      tag_id_q[0]  <= iss_id_q;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  assign mul_valid_o  = mul_valid_q;
  assign mul_opA_o    = mul_opA_q;
  assign mul_opB_o    = mul_opB_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_data_o  = resp_data_q;
  assign op_count_o   = op_count_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fpmul_rr_sched.sv
// tb_fpmul_rr_sched: bench for fpmul_rr_sched with a behavioural LAT-cycle FP16
// multiplier, per-requester operand drivers and an in-order response scoreboard.
module tb_fpmul_rr_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 3;
  localparam int unsigned IDW  = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [16*NREQ-1:0]  req_opA;
  logic [16*NREQ-1:0]  req_opB;
  logic [NREQ-1:0]     req_ready;
  logic                mul_valid;
  logic [15:0]         mul_opA;
  logic [15:0]         mul_opB;
  logic                mul_vld_in;
  logic [15:0]         mul_res;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [15:0]         resp_data;
  logic [15:0]         op_count;
  logic                err;

  fpmul_rr_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_opA_i   (req_opA),
    .req_opB_i   (req_opB),
    .req_ready_o (req_ready),
    .mul_valid_o (mul_valid),
    .mul_opA_o   (mul_opA),
    .mul_opB_o   (mul_opB),
    .mul_valid_i (mul_vld_in),
    .mul_res_i   (mul_res),
    .resp_valid_o(resp_valid),
    .resp_id_o   (resp_id),
    .resp_data_o (resp_data),
    .op_count_o  (op_count),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Normal-range FP16 multiply with truncation; operands stay in range.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] m;
    logic [5:0]  e;
    logic        s;
    s = a[15] ^ b[15];
    m = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = 6'(a[14:10]) + 6'(b[14:10]) - 6'd15;
    if (m[21]) begin
      e = e + 6'd1;
      return {s, e[4:0], m[20:11]};
    end
    return {s, e[4:0], m[19:10]};
  endfunction

  function automatic logic [15:0] rnd_fp();
    logic [15:0] v;
    v[15]    = 1'($urandom);
    v[14:10] = 5'($urandom_range(18, 12));
    v[9:0]   = 10'($urandom);
    return v;
  endfunction

  // Behavioural multiplier: product returns exactly LAT cycles after issue.
  logic        mdl_v [LAT] = '{default: 1'b0};
  logic [15:0] mdl_d [LAT];
  logic        inj;

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      mdl_v[i] <= mdl_v[i-1];
      mdl_d[i] <= mdl_d[i-1];
    end
    mdl_v[0] <= mul_valid;
    mdl_d[0] <= fmul(mul_opA, mul_opB);
  end

  assign mul_vld_in = mdl_v[LAT-1] | inj;
  assign mul_res    = mdl_d[LAT-1];

  typedef struct {
    int unsigned id;
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t            sb[$];
  logic [NREQ-1:0] acc_mask = '0;
  logic [15:0]     cnt_mdl  = '0;
  int unsigned     cyc      = 0;
  bit              mon_en   = 1'b0;
  int unsigned     last_id, last_data, last_lat;

  // Monitor: push on accept, pop and compare on response, track issue count.
  always @(negedge clk) begin
    exp_t e;
    acc_mask = req_valid & req_ready;
    if (mon_en) begin
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      check("op_count", 32'(op_count), 32'(cnt_mdl));
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_id", 32'(resp_id), e.id);
          check("resp_data", 32'(resp_data), 32'(e.data));
          check("resp_latency", cyc - e.cyc, LAT + 2);
          last_id   = 32'(resp_id);
          last_data = 32'(resp_data);
          last_lat  = cyc - e.cyc;
        end
      end
      if (rst) begin
        sb.delete();
        cnt_mdl = '0;
      end else begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          if (acc_mask[k]) begin
            sb.push_back('{id: k, data: fmul(req_opA[16*k +: 16], req_opB[16*k +: 16]), cyc: cyc});
            cnt_mdl = cnt_mdl + 16'd1;
          end
        end
      end
    end
    cyc++;
  end

  int unsigned pend [NREQ] = '{default: 0};

  // One cycle: refresh operands of accepted requesters, drive valid from pending work.
  task automatic step();
    @(posedge clk);
    #1;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (acc_mask[k]) begin
        pend[k]--;
        req_opA[16*k +: 16] = rnd_fp();
        req_opB[16*k +: 16] = rnd_fp();
      end
      req_valid[k] = (pend[k] != 0);
    end
    #1;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n;
    bit busy;
    n = 0;
    do begin
      step();
      n++;
      busy = (sb.size() != 0);
      for (int unsigned k = 0; k < NREQ; k++) if (pend[k] != 0) busy = 1'b1;
    end while (busy && n < budget);
    if (busy) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) step();
  endtask

  // Ready stays low for LAT+1 cycles after reset falls, then the given grant appears.
  task automatic drain_then_grant(input logic [NREQ-1:0] exp_gnt);
    check("drain_ready", 32'(req_ready), 32'd0);
    for (int unsigned i = 0; i < LAT; i++) begin
      step();
      check("drain_ready", 32'(req_ready), 32'd0);
    end
    step();
    check("first_grant", 32'(req_ready), 32'(exp_gnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout, %0d errors so far", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst       = 1'b1;
    inj       = 1'b0;
    req_valid = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      req_opA[16*k +: 16] = rnd_fp();
      req_opB[16*k +: 16] = rnd_fp();
    end

    // Reset state and post-reset drain with all requesters pending.
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    repeat (3) step();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_mul_valid", 32'(mul_valid), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    drain_then_grant(4'b0001);
    step(); check("rr_grant1", 32'(req_ready), 32'b0010);
    step(); check("rr_grant2", 32'(req_ready), 32'b0100);
    step(); check("rr_grant3", 32'(req_ready), 32'b1000);
    step(); check("rr_grant0", 32'(req_ready), 32'b0001);
    wait_idle(200);
    check("t1_op_count", 32'(op_count), 32'd5);

    // Single request 1.0 * 2.0 from requester 2.
    req_opA[32 +: 16] = 16'h3C00;
    req_opB[32 +: 16] = 16'h4000;
    pend[2] = 1;
    wait_idle(200);
    check("t2_id", last_id, 32'd2);
    check("t2_data", last_data, 32'h4000);
    check("t2_latency", last_lat, 32'd5);

    // Move pointer to 2, then requesters 1 and 3 contend for 8 cycles.
    pend[1] = 1;
    wait_idle(200);
    pend[1] = 4;
    pend[3] = 4;
    step();
    for (int unsigned i = 0; i < 8; i++) begin
      check("alt_grant", 32'(req_ready), (i % 2 == 0) ? 32'b1000 : 32'b0010);
      step();
    end
    wait_idle(200);
    check("t3_err", 32'(err), 32'd0);

    // Unexpected product with no tag in flight.
    inj = 1'b1;
    step();
    inj = 1'b0;
    check("inj_err", 32'(err), 32'd1);
    check("inj_resp", 32'(resp_valid), 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check("err_sticky", 32'(err), 32'd1);
      check("inj_no_resp", 32'(resp_valid), 32'd0);
    end

    // Reset while three products are in flight; they must drain silently.
    pend[0] = 1; pend[1] = 1; pend[2] = 1;
    repeat (4) step();
    rst     = 1'b1;
    pend[3] = 1;
    step();
    rst = 1'b0;
    check("post_rst_err", 32'(err), 32'd0);
    drain_then_grant(4'b1000);
    wait_idle(200);
    check("t5_err", 32'(err), 32'd0);
    check("t5_op_count", 32'(op_count), 32'd1);

    // Run the counter up to 0xFFFE, then step across the wrap.
    n = 32'hFFFE - 32'(cnt_mdl);
    for (int unsigned k = 0; k < NREQ; k++) begin
      pend[k] = n / NREQ + ((k < n % NREQ) ? 1 : 0);
    end
    wait_idle(70000);
    check("cnt_fffe", 32'(op_count), 32'hFFFE);
    pend[0] = 1;
    wait_idle(200);
    check("cnt_ffff", 32'(op_count), 32'hFFFF);
    pend[1] = 1;
    wait_idle(200);
    check("cnt_wrap", 32'(op_count), 32'h0000);
    check("final_err", 32'(err), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpmul_rr_sched.md
Name: fpmul_rr_sched

Overview:
- Round-robin scheduler that shares one fixed-latency FP16 multiplier between NREQ requesters.
- Arbitrates operand requests and issues at most one multiply per cycle.
- Tracks the requester ID of each in-flight operation in a tag pipeline, and routes each returning product back to the requester that issued it.
- Sits between the vector/lane front-end and the single shared FP16 multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 3, multiplier latency in cycles from mul_valid_o to mul_valid_i (1..8).
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NREQ  per-requester operand-pair valid.
- req_opA_i  in  16*NREQ  packed FP16 operand A; requester k occupies [16k+15:16k].
- req_opB_i  in  16*NREQ  packed FP16 operand B, same packing.
- req_ready_o  out  NREQ  one-hot grant; a request is accepted when valid and ready are both high.
- mul_valid_o  out  1  issue strobe to the shared multiplier.
- mul_opA_o  out  16  operand A to the multiplier.
- mul_opB_o  out  16  operand B to the multiplier.
- mul_valid_i  in  1  product valid from the multiplier.
- mul_res_i  in  16  FP16 product.
- resp_valid_o  out  1  response strobe; there is no backpressure.
- resp_id_o  out  IDW  requester index owning the response.
- resp_data_o  out  16  FP16 product.
- op_count_o  out  16  number of multiplies issued since reset; wraps at 0xFFFF -> 0.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - All registered outputs are 0.
  - Round-robin pointer = 0.
  - Tag pipeline cleared.
  - drain counter = LAT+1.
- Arbitration (combinational):
  - Search starts at the pointer and proceeds upward, wrapping at NREQ-1 -> 0.
  - The first requester with valid high gets req_ready_o.
  - req_ready_o is all-zero while rst_i is high or while drain > 0.
  - req_ready_o is at most one-hot.
  - A requester may assert valid without waiting for ready.
  - Operands must stay stable until accepted.
- Pointer update:
  - On an accept from requester k, the pointer becomes (k+1) mod NREQ.
  - With no accept, the pointer holds.
  - Bound: a continuously requesting requester is served within NREQ cycles.
- Issue:
  - An accept in cycle T registers the operands and drives mul_valid_o=1 in cycle T+1.
  - mul_opA_o/mul_opB_o keep the last issued value when mul_valid_o=0.
  - op_count_o increments in T+1.
- Tag pipeline:
  - LAT-stage shift register of {valid, id}, advancing every cycle.
  - Stage 0 loads {mul_valid_o, id of issued op}.
  - The stage-LAT-1 output is compared with mul_valid_i.
- Return:
  - mul_valid_i in cycle T+1+LAT is registered.
  - resp_valid_o=1, resp_id_o=tag id and resp_data_o=mul_res_i appear in cycle T+2+LAT.
  - Total latency from accept to response is LAT+2 cycles.
  - Back-to-back accepts give back-to-back responses, in issue order.
- Errors (outside drain):
  - If mul_valid_i differs from the tag valid at the compare stage, set err_o=1.
  - err_o stays set until reset.
  - A product arriving with no matching tag is dropped; resp_valid_o=0.
  - A missing product for an expected tag produces no response.
- Reset mid-operation:
  - All in-flight tags are discarded.
  - The drain counter decrements each cycle after rst_i falls.
  - While drain > 0:
    - no grants are issued;
    - mul_valid_i is ignored with no response and no error.
  - This lets stale products from pre-reset issues flush out.
- Simultaneous events:
  - Accept, issue and return can all occur in the same cycle; they are independent.
  - An op_count_o wrap and an error in the same cycle are both honoured.
- Data is passed through bit-exact; the scheduler performs no arithmetic on operands or products.

Test Plan:
- Reset, then hold for LAT+1 cycles with req_valid_i=4'b1111 -> req_ready_o stays 0; then grants go to 0,1,2,3,0 in consecutive cycles; op_count_o=5 after 5 issues.
- Requester 2 alone sends opA=0x3C00 (1.0), opB=0x4000 (2.0); model returns 0x4000 after LAT=3 -> resp_valid_o=1, resp_id_o=2, resp_data_o=0x4000, exactly 5 cycles after the accept cycle.
- Requesters 1 and 3 both hold valid for 8 cycles with pointer=2 -> grant order 3,1,3,1,...; no requester waits more than 1 cycle; responses alternate ids 3,1 in order.
- Model injects mul_valid_i=1 with an empty tag stage (after drain) -> err_o=1 next cycle and stays 1; resp_valid_o stays 0.
- Issue 3 ops, then assert rst_i for 1 cycle while they are in flight; model still returns 3 products -> no resp_valid_o, err_o=0; grants resume LAT+1 cycles after rst_i falls.
- Preload op_count_o to 0xFFFE via 0xFFFE issues (or a forced value), then issue 2 ops -> op_count_o reads 0xFFFF, then 0x0000.
